// File: rtl/ika2151_pkg.sv
// Shared constants and types for the IKA2151 serial-output deserializer and
// its floating-point-to-PCM decoder.
package ika2151_pkg;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned MANT_W    = 10;
  localparam int unsigned EXP_W     = 3;
  localparam int unsigned PCM_W     = 16;
  localparam int unsigned MANT_LSB  = 3;
  localparam int unsigned EXP_LSB   = 13;

  typedef enum logic {
    CH_1 = 1'b0,
    CH_2 = 1'b1
  } ch_e;

endpackage

// File: rtl/ika2151_so_deserializer_if.sv
// Decoded PCM output bus of the deserializer; master drives, slave observes.
interface ika2151_so_deserializer_if;
  import ika2151_pkg::*;

  logic signed [PCM_W-1:0] o_CH1;
  logic signed [PCM_W-1:0] o_CH2;
  logic                    o_CH1_VALID;
  logic                    o_CH2_VALID;
  logic                    o_FRAME_ERR;

  modport master (output o_CH1, o_CH2, o_CH1_VALID, o_CH2_VALID, o_FRAME_ERR);
  modport slave  (input  o_CH1, o_CH2, o_CH1_VALID, o_CH2_VALID, o_FRAME_ERR);

endinterface

// File: rtl/ika2151_fp_decode.sv
// Combinational YM3012-style float (10-bit mantissa, 3-bit exponent) to
// 16-bit signed linear PCM converter.
module ika2151_fp_decode
  import ika2151_pkg::*;
#(
  parameter bit ZERO_EXP_MUTE = 1'b1
) (
  input  logic        [MANT_W-1:0] i_mant,
  input  logic        [EXP_W-1:0]  i_exp,
  output logic signed [PCM_W-1:0]  o_pcm
);

  logic signed [MANT_W-1:0] w_m;
  logic signed [PCM_W-1:0]  w_ext;
  logic        [EXP_W-1:0]  w_sh;

  // Mantissa MSB is an inverted sign bit (offset binary).
  assign w_m   = {~i_mant[MANT_W-1], i_mant[MANT_W-2:0]};
  assign w_ext = {{(PCM_W-MANT_W){w_m[MANT_W-1]}}, w_m};
  assign w_sh  = i_exp - EXP_W'(1);

  always_comb begin
    o_pcm = w_ext;
    if (i_exp == '0) begin
      o_pcm = ZERO_EXP_MUTE ? '0 : w_ext;
    end else begin
      o_pcm = w_ext <<< w_sh;
    end
  end

endmodule

// File: rtl/ika2151_so_deserializer.sv
// IKA2151 SO stream deserializer: frames words on SH1/SH2 falling edges and
// decodes them into per-channel PCM, two EMUCLK stages after the edge cycle.
module ika2151_so_deserializer
  import ika2151_pkg::*;
#(
  parameter bit ZERO_EXP_MUTE = 1'b1,
  parameter bit CHECK_FRAME   = 1'b1
) (
  input  logic                              i_EMUCLK,
  input  logic                              i_MRST_n,
  input  logic                              i_phi1_PCEN_n,
  input  logic                              i_SO,
  input  logic                              i_SH1,
  input  logic                              i_SH2,
  ika2151_so_deserializer_if.master         o_pcm
);

  logic                           w_en;
  logic                           w_fall1;
  logic                           w_fall2;
  logic                           w_edge;
  logic                           w_len_bad;
  logic [FRAME_LEN-1:MANT_LSB]    w_word;

  // Bits 0..2 of a word are don't-care, so only the upper bits are kept.
  logic [FRAME_LEN-1:MANT_LSB]    r_shift;
  logic                           r_prev_sh1;
  logic                           r_prev_sh2;
  logic [4:0]                     r_cnt;
  logic                           r_armed;

  logic                           r_s1_vld;
  ch_e                            r_s1_ch;
  logic [FRAME_LEN-1:MANT_LSB]    r_s1_word;
  logic                           r_s1_err;

  logic signed [PCM_W-1:0]        w_pcm;

  assign w_en      = ~i_phi1_PCEN_n;
  assign w_word    = {i_SO, r_shift[FRAME_LEN-1:MANT_LSB+1]};
  assign w_fall1   = w_en & r_prev_sh1 & ~i_SH1;
  assign w_fall2   = w_en & r_prev_sh2 & ~i_SH2;
  assign w_edge    = w_fall1 | w_fall2;
  assign w_len_bad = CHECK_FRAME && r_armed && (r_cnt != 5'(FRAME_LEN));

  always_ff @(posedge i_EMUCLK) begin
    if (!i_MRST_n) begin
      r_shift    <= '0;
      r_prev_sh1 <= 1'b0;
      r_prev_sh2 <= 1'b0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_s1_ch    <= CH_1;
      r_s1_word  <= '0;
      r_s1_err   <= 1'b0;
    end else begin
      r_s1_vld <= 1'b0;
      if (w_en) begin
        r_shift    <= w_word;
        r_prev_sh1 <= i_SH1;
        r_prev_sh2 <= i_SH2;
        if (w_edge) begin
          r_cnt     <= 5'd1;
          r_armed   <= 1'b1;
          r_s1_vld  <= 1'b1;
          r_s1_word <= w_word;
          // Channel 1 wins a simultaneous edge; the collision is a framing error.
          r_s1_ch   <= w_fall1 ? CH_1 : CH_2;
          r_s1_err  <= w_len_bad | (w_fall1 & w_fall2);
        end else if (r_cnt != 5'd31) begin
          r_cnt <= r_cnt + 5'd1;
        end
      end
    end
  end

  ika2151_fp_decode #(
    .ZERO_EXP_MUTE (ZERO_EXP_MUTE)
  ) u_decode (
    .i_mant (r_s1_word[MANT_LSB +: MANT_W]),
    .i_exp  (r_s1_word[EXP_LSB  +: EXP_W]),
    .o_pcm  (w_pcm)
  );

  always_ff @(posedge i_EMUCLK) begin
    if (!i_MRST_n) begin
      o_pcm.o_CH1       <= '0;
      o_pcm.o_CH2       <= '0;
      o_pcm.o_CH1_VALID <= 1'b0;
      o_pcm.o_CH2_VALID <= 1'b0;
      o_pcm.o_FRAME_ERR <= 1'b0;
    end else begin
      o_pcm.o_CH1_VALID <= 1'b0;
      o_pcm.o_CH2_VALID <= 1'b0;
      if (r_s1_vld) begin
        if (r_s1_ch == CH_1) begin
          o_pcm.o_CH1       <= w_pcm;
          o_pcm.o_CH1_VALID <= 1'b1;
        end else begin
          o_pcm.o_CH2       <= w_pcm;
          o_pcm.o_CH2_VALID <= 1'b1;
        end
        if (r_s1_err) begin
          o_pcm.o_FRAME_ERR <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ika2151_so_deserializer.sv
// Scoreboard bench for ika2151_so_deserializer: one instance per zero-exponent
// mode, fed the same SO/SH stream, checked by per-instance monitors.
module tb_ika2151_so_deserializer;
  import ika2151_pkg::*;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pcen_n = 1'b1;
  logic so     = 1'b0;
  logic sh1    = 1'b0;
  logic sh2    = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          ch;
    logic [15:0] pcm;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ika2151_so_deserializer_if pcm_a ();
  ika2151_so_deserializer_if pcm_b ();

  ika2151_so_deserializer #(
    .ZERO_EXP_MUTE (1'b1),
    .CHECK_FRAME   (1'b1)
  ) dut_a (
    .i_EMUCLK      (clk),
    .i_MRST_n      (rst_n),
    .i_phi1_PCEN_n (pcen_n),
    .i_SO          (so),
    .i_SH1         (sh1),
    .i_SH2         (sh2),
    .o_pcm         (pcm_a)
  );

  ika2151_so_deserializer #(
    .ZERO_EXP_MUTE (1'b0),
    .CHECK_FRAME   (1'b1)
  ) dut_b (
    .i_EMUCLK      (clk),
    .i_MRST_n      (rst_n),
    .i_phi1_PCEN_n (pcen_n),
    .i_SO          (so),
    .i_SH1         (sh1),
    .i_SH2         (sh2),
    .o_pcm         (pcm_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: offset-binary mantissa scaled by 2^(e-1), written arithmetically.
  function automatic logic [15:0] model(input logic [15:0] w, input bit mute);
    int e;
    int mv;
    e  = int'(w[15:13]);
    mv = w[12] ? int'(w[11:3]) : int'(w[11:3]) - 512;
    if (e == 0) return mute ? 16'h0000 : 16'(mv);
    return 16'(mv * (1 << (e - 1)));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the top nbits of w LSB first, one enabled clock then one idle clock
  // per bit; the selected strobes are high for bits 8..14 and fall on bit 15.
  task automatic send(input logic [15:0] w, input bit c1, input bit c2, input int nbits = 16);
    exp_t ea;
    exp_t eb;
    for (int i = 16 - nbits; i < 16; i++) begin
      @(negedge clk);
      pcen_n = 1'b0;
      so     = w[i];
      sh1    = c1 && (i >= 8) && (i < 15);
      sh2    = c2 && (i >= 8) && (i < 15);
      if (i == 15 && (c1 || c2)) begin
        ea.ch = !c1; ea.pcm = model(w, 1'b1); ea.at = cyc + 2;
        eb.ch = !c1; eb.pcm = model(w, 1'b0); eb.at = cyc + 2;
        qa.push_back(ea);
        qb.push_back(eb);
      end
      @(negedge clk);
      pcen_n = 1'b1;
    end
    so = 1'b0;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && (pcm_a.o_CH1_VALID || pcm_a.o_CH2_VALID)) begin
      chk("a_one_channel", {31'd0, pcm_a.o_CH1_VALID & pcm_a.o_CH2_VALID}, 32'd0);
      chk("a_expected_word", {31'd0, qa.size() != 0}, 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_channel", {31'd0, pcm_a.o_CH2_VALID}, {31'd0, e.ch});
        chk("a_latency", cyc, e.at);
        chk("a_pcm", e.ch ? {16'd0, $unsigned(pcm_a.o_CH2)} : {16'd0, $unsigned(pcm_a.o_CH1)},
            {16'd0, e.pcm});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && (pcm_b.o_CH1_VALID || pcm_b.o_CH2_VALID)) begin
      chk("b_one_channel", {31'd0, pcm_b.o_CH1_VALID & pcm_b.o_CH2_VALID}, 32'd0);
      chk("b_expected_word", {31'd0, qb.size() != 0}, 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_channel", {31'd0, pcm_b.o_CH2_VALID}, {31'd0, e.ch});
        chk("b_latency", cyc, e.at);
        chk("b_pcm", e.ch ? {16'd0, $unsigned(pcm_b.o_CH2)} : {16'd0, $unsigned(pcm_b.o_CH1)},
            {16'd0, e.pcm});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;

    rst_n = 1'b0;
    idle(3);
    chk("rst_a_ch1", {16'd0, $unsigned(pcm_a.o_CH1)}, 32'd0);
    chk("rst_a_ch2", {16'd0, $unsigned(pcm_a.o_CH2)}, 32'd0);
    chk("rst_a_v1",  {31'd0, pcm_a.o_CH1_VALID}, 32'd0);
    chk("rst_a_v2",  {31'd0, pcm_a.o_CH2_VALID}, 32'd0);
    chk("rst_a_err", {31'd0, pcm_a.o_FRAME_ERR}, 32'd0);
    chk("rst_b_ch1", {16'd0, $unsigned(pcm_b.o_CH1)}, 32'd0);
    rst_n = 1'b1;

    // 1 * 2^(3-1) = 4 on channel 1; channel 2 untouched.
    send({3'b011, 10'b10_0000_0001, 3'b000}, 1'b1, 1'b0);
    idle(4);
    chk("basic_ch1",      {16'd0, $unsigned(pcm_a.o_CH1)}, 32'h0004);
    chk("basic_ch2_hold", {16'd0, $unsigned(pcm_a.o_CH2)}, 32'h0000);

    send({3'd7, 10'h000, 3'b101}, 1'b0, 1'b1);
    idle(2);
    chk("fs_neg_ch2", {16'd0, $unsigned(pcm_a.o_CH2)}, 32'h8000);
    send({3'd7, 10'h3FF, 3'b000}, 1'b1, 1'b0);
    idle(2);
    chk("fs_pos_ch1", {16'd0, $unsigned(pcm_a.o_CH1)}, 32'h7FC0);
    send({3'd0, 10'h3FF, 3'b000}, 1'b1, 1'b0);
    idle(2);
    chk("exp0_mute",   {16'd0, $unsigned(pcm_a.o_CH1)}, 32'h0000);
    chk("exp0_nomute", {16'd0, $unsigned(pcm_b.o_CH1)}, 32'h01FF);

    for (int k = 0; k < 64; k++) begin
      w = 16'($urandom);
      send(w, (k % 2) == 0, (k % 2) == 1);
    end
    idle(4);
    chk("stream_err_a", {31'd0, pcm_a.o_FRAME_ERR}, 32'd0);
    chk("stream_err_b", {31'd0, pcm_b.o_FRAME_ERR}, 32'd0);

    send(16'h5A5A, 1'b0, 1'b1, 15);
    idle(4);
    chk("short_err_a", {31'd0, pcm_a.o_FRAME_ERR}, 32'd1);
    chk("short_err_b", {31'd0, pcm_b.o_FRAME_ERR}, 32'd1);
    send(16'h1234, 1'b1, 1'b0);
    idle(4);
    chk("err_sticky", {31'd0, pcm_a.o_FRAME_ERR}, 32'd1);

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    send({3'd5, 10'h3C1, 3'b010}, 1'b1, 1'b0);
    idle(4);
    chk("armed_no_err", {31'd0, pcm_a.o_FRAME_ERR}, 32'd0);
    send({3'd4, 10'h2AB, 3'b000}, 1'b1, 1'b1);
    idle(4);
    chk("simul_err",     {31'd0, pcm_a.o_FRAME_ERR}, 32'd1);
    chk("simul_ch1",     {16'd0, $unsigned(pcm_a.o_CH1)}, 32'h0558);
    chk("simul_ch2_hold", {16'd0, $unsigned(pcm_a.o_CH2)}, 32'h0000);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pcen_n = 1'b0;
      so     = 1'b1;
      sh1    = (i > 4);
      @(negedge clk);
      pcen_n = 1'b1;
    end
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    sh1 = 1'b0;
    chk("midrst_ch1", {16'd0, $unsigned(pcm_a.o_CH1)}, 32'd0);
    chk("midrst_ch2", {16'd0, $unsigned(pcm_a.o_CH2)}, 32'd0);
    chk("midrst_err", {31'd0, pcm_a.o_FRAME_ERR}, 32'd0);
    idle(4);
    chk("midrst_no_valid", {31'd0, pcm_a.o_CH1_VALID | pcm_a.o_CH2_VALID}, 32'd0);
    send({3'd2, 10'h155, 3'b111}, 1'b1, 1'b0);
    idle(4);
    chk("post_rst_ch1", {16'd0, $unsigned(pcm_a.o_CH1)}, 32'h0000FEAA);
    chk("post_rst_err", {31'd0, pcm_a.o_FRAME_ERR}, 32'd0);

    idle(10);
    chk("drain_a", qa.size(), 32'd0);
    chk("drain_b", qb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
